// File: rtl/sticky_flag_reader.sv
// sticky_flag_reader
//
// Reader end of a set-and-hold flag source. The flag is synchronised into
// the clk domain, and each event is timestamped from a free-running cycle
// counter and offered to a consumer over a valid/ready handshake. A clear
// request then goes back to the source. If the flag fails to drop within
// CLR_TIMEOUT cycles of the request, it is reported as stuck.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset, released synchronously
//   flag_in    sticky flag from the source (may be asynchronous)
//   flag_clr   registered clear request to the source
//   evt_valid  event record available
//   evt_ready  consumer accepts the record
//   evt_time   timer value at event capture
//   evt_count  saturating count of captured events
//   overflow   sticky: an event was captured while a record was still pending
//   stuck      flag did not drop within CLR_TIMEOUT cycles of a clear request
module sticky_flag_reader #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_in,
  output logic             flag_clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_time,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             stuck
);

  localparam logic [15:0] WAIT_LAST = 16'(CLR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   flag_s;
  logic [CNT_W-1:0]       timer_q;
  logic [15:0]            wait_q;
  logic [15:0]            wait_d;
  logic                   clr_d;
  logic                   stuck_d;
  logic                   capture;
  logic                   take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Synchroniser: flag_in -> flag_s, SYNC_STAGES flops deep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], flag_in};
  end

  assign flag_s = sync_q[SYNC_STAGES-1];

  // Free-running timer, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_q <= '0;
    else      timer_q <= timer_q + 1'b1;
  end

  // FSM state, wait counter and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      flag_clr <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      flag_clr <= clr_d;
      stuck    <= stuck_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    clr_d   = flag_clr;
    stuck_d = stuck;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (flag_s) begin
          capture = 1'b1;
          clr_d   = 1'b1;
          wait_d  = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // A dropped flag takes priority over the timeout on the same cycle.
        if (!flag_s) begin
          clr_d   = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          stuck_d = 1'b1;
          wait_d  = '0;
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      FAULT: begin
        if (!flag_s) begin
          clr_d   = 1'b0;
          stuck_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        clr_d   = 1'b0;
        stuck_d = 1'b0;
        wait_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A new capture may replace the pending record only if that record is
  // being accepted in the same cycle; otherwise the old record is kept.
  assign take = capture && (!evt_valid || evt_ready);

  // Event record and handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_time  <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        evt_count <= sat_inc(evt_count);
        if (take) begin
          evt_time  <= timer_q;
          evt_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sticky_flag_reader.sv
// Testbench for sticky_flag_reader (CNT_W=4, SYNC_STAGES=2, CLR_TIMEOUT=4).
module tb_sticky_flag_reader;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;
  localparam int TMO   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flag_in = 1'b0;
  logic             evt_ready = 1'b0;
  logic             flag_clr;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_time;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             stuck;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sticky_flag_reader #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .CLR_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flag_in  (flag_in),
    .flag_clr (flag_clr),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_time (evt_time),
    .evt_count(evt_count),
    .overflow (overflow),
    .stuck    (stuck)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model. The flag history queue stands in for the
  // synchroniser; "clearing" is simply a pending clear request and "fault"
  // is a pending clear request that has already been declared stuck.
  int m_timer;
  int m_time;
  int m_count;
  int m_clear_cycles;
  bit m_valid;
  bit m_clr;
  bit m_ovf;
  bit m_stuck;
  bit m_hist[$];
  bit fs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_timer = 0; m_time = 0; m_count = 0; m_clear_cycles = 0;
      m_valid = 0; m_clr = 0; m_ovf = 0; m_stuck = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(1'b0);
    end else begin
      fs = m_hist[SYNC-1];
      if (!m_clr) begin
        if (fs) begin
          m_count = (m_count == CMAX) ? CMAX : m_count + 1;
          if (!m_valid || evt_ready) begin
            m_time  = m_timer;
            m_valid = 1;
          end else begin
            m_ovf = 1;
          end
          m_clr = 1;
          m_clear_cycles = 0;
        end else if (m_valid && evt_ready) begin
          m_valid = 0;
        end
      end else begin
        if (m_valid && evt_ready) m_valid = 0;
        if (!fs) begin
          m_clr   = 0;
          m_stuck = 0;
        end else if (!m_stuck) begin
          m_clear_cycles++;
          if (m_clear_cycles == TMO) m_stuck = 1;
        end
      end
      m_timer = (m_timer + 1) % (CMAX + 1);
      m_hist.push_front(flag_in);
      void'(m_hist.pop_back());
    end
  end

  bit bg_en = 1'b1;

  always @(negedge clk) begin
    if (bg_en) begin
      check("mdl_valid", 32'(evt_valid), 32'(m_valid));
      check("mdl_clr",   32'(flag_clr),  32'(m_clr));
      check("mdl_time",  32'(evt_time),  m_time);
      check("mdl_count", 32'(evt_count), m_count);
      check("mdl_ovf",   32'(overflow),  32'(m_ovf));
      check("mdl_stuck", 32'(stuck),     32'(m_stuck));
    end
  end

  typedef struct {
    bit flag;
    bit ready;
    bit valid;
    bit clr;
    int tim;
    int cnt;
  } vec_t;

  function automatic vec_t mk(input bit f, input bit r, input bit v, input bit c,
                              input int t, input int n);
    vec_t x;
    x.flag = f; x.ready = r; x.valid = v; x.clr = c; x.tim = t; x.cnt = n;
    return x;
  endfunction

  vec_t tbl[9];

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0; flag_in = 1'b0; evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_clr(input logic lvl, input string name);
    int n = 0;
    while (flag_clr !== lvl && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(flag_clr), 32'(lvl));
  endtask

  task automatic pulse_event();
    @(posedge clk);
    #1 flag_in = 1'b1;
    wait_clr(1'b1, "clr_rise");
    @(posedge clk);
    #1 flag_in = 1'b0;
    wait_clr(1'b0, "clr_fall");
  endtask

  initial begin
    int n;
    int t1;

    // Rows: inputs driven just after edge r, outputs checked after edge r.
    // flag_in rises at the edge ending the timer==10 cycle; capture sees 13.
    tbl[0] = mk(1, 1, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 0, 0, 0);
    tbl[2] = mk(1, 1, 0, 0, 0, 0);
    tbl[3] = mk(1, 1, 1, 1, 13, 1);
    tbl[4] = mk(0, 1, 0, 1, 13, 1);
    tbl[5] = mk(0, 1, 0, 1, 13, 1);
    tbl[6] = mk(0, 1, 0, 1, 13, 1);
    tbl[7] = mk(0, 1, 0, 0, 13, 1);
    tbl[8] = mk(0, 1, 0, 0, 13, 1);

    // Reset, then idle with the timer wrapping
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_clr",   32'(flag_clr),  32'd0);
    check("rst_time",  32'(evt_time),  32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_stuck", 32'(stuck),     32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_valid", 32'(evt_valid), 32'd0);
    check("idle_clr",   32'(flag_clr),  32'd0);
    check("idle_count", 32'(evt_count), 32'd0);

    // Single event, table driven
    n = 0;
    while (m_timer != 10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("align_timer", 32'(m_timer), 32'd10);
    for (int r = 0; r < 9; r++) begin
      @(posedge clk);
      #1 flag_in = tbl[r].flag; evt_ready = tbl[r].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", r), 32'(evt_valid), 32'(tbl[r].valid));
      check($sformatf("tbl%0d_clr", r),   32'(flag_clr),  32'(tbl[r].clr));
      check($sformatf("tbl%0d_time", r),  32'(evt_time),  tbl[r].tim);
      check($sformatf("tbl%0d_count", r), 32'(evt_count), tbl[r].cnt);
      check($sformatf("tbl%0d_ovf", r),   32'(overflow),  32'd0);
    end

    // Backpressure overflow
    do_reset();
    evt_ready = 1'b0;
    pulse_event();
    t1 = m_time;
    check("bp_valid1", 32'(evt_valid), 32'd1);
    pulse_event();
    check("bp_count", 32'(evt_count), 32'd2);
    check("bp_ovf",   32'(overflow),  32'd1);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_time",  32'(evt_time),  t1);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    @(negedge clk);
    check("bp_drop", 32'(evt_valid), 32'd0);
    check("bp_ovf_hold", 32'(overflow), 32'd1);

    // Simultaneous accept and capture
    do_reset();
    evt_ready = 1'b0;
    pulse_event();
    @(posedge clk);
    #1 flag_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    @(negedge clk);
    check("sim_valid", 32'(evt_valid), 32'd1);
    check("sim_ovf",   32'(overflow),  32'd0);
    check("sim_count", 32'(evt_count), 32'd2);
    check("sim_time",  32'(evt_time),  (m_timer + CMAX) % (CMAX + 1));
    @(posedge clk);
    #1 flag_in = 1'b0;
    wait_clr(1'b0, "sim_clr_fall");

    // Stuck flag
    do_reset();
    evt_ready = 1'b1;
    @(posedge clk);
    #1 flag_in = 1'b1;
    wait_clr(1'b1, "stk_clr_rise");
    check("stk_early", 32'(stuck), 32'd0);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      check($sformatf("stk_wait%0d", k), 32'(stuck), 32'd0);
    end
    @(negedge clk);
    check("stk_set", 32'(stuck),    32'd1);
    check("stk_clr", 32'(flag_clr), 32'd1);
    repeat (6) @(negedge clk);
    check("stk_count", 32'(evt_count), 32'd1);
    check("stk_hold",  32'(stuck),     32'd1);
    @(posedge clk);
    #1 flag_in = 1'b0;
    for (int k = 0; k < SYNC + 1; k++) begin
      @(negedge clk);
      check($sformatf("stk_drain%0d", k), 32'(stuck), 32'd1);
    end
    @(negedge clk);
    check("stk_release", 32'(stuck),    32'd0);
    check("stk_clr_off", 32'(flag_clr), 32'd0);

    // Saturating event count
    do_reset();
    evt_ready = 1'b1;
    repeat (17) pulse_event();
    check("sat_count", 32'(evt_count), 32'(CMAX));

    // Asynchronous reset in the middle of CLEAR
    do_reset();
    evt_ready = 1'b0;
    @(posedge clk);
    #1 flag_in = 1'b1;
    wait_clr(1'b1, "ar_clr_rise");
    check("ar_valid_pre", 32'(evt_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_clr",   32'(flag_clr),  32'd0);
    check("ar_valid", 32'(evt_valid), 32'd0);
    check("ar_count", 32'(evt_count), 32'd0);
    flag_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomised source and consumer against the model
    repeat (1500) begin
      @(posedge clk);
      #1;
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        flag_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end else if (flag_in && flag_clr) begin
        if ($urandom_range(0, 3) == 0) flag_in = 1'b0;
      end else if (!flag_in) begin
        if ($urandom_range(0, 3) == 0) flag_in = 1'b1;
      end
    end
    @(negedge clk);
    bg_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
